// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants for the hex display scanner
package display_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam int         SEG_DP    = 7;
    localparam int         SEG_A     = 0;
    localparam int         SEG_G     = 6;

    // Active-low 7-segment glyphs, index = nibble value; bit 0 = segment a.
    localparam logic [15:0][6:0] GLYPHS = {
        7'h0E,  // F
        7'h06,  // E
        7'h21,  // d
        7'h46,  // C
        7'h03,  // b
        7'h08,  // A
        7'h10,  // 9
        7'h00,  // 8
        7'h78,  // 7
        7'h02,  // 6
        7'h12,  // 5
        7'h19,  // 4
        7'h30,  // 3
        7'h24,  // 2
        7'h79,  // 1
        7'h40   // 0
    };

endpackage

// File: rtl/hex_seg_decode.sv
// rtl/hex_seg_decode.sv - combinational nibble to active-low 7-segment glyph
module hex_seg_decode
    import display_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] glyph_o
);

    assign glyph_o = GLYPHS[nibble_i];

endmodule

// File: rtl/hex_display_scanner.sv
// rtl/hex_display_scanner.sv - time-multiplexed hex display driver with LZB, blink and alarm DP
module hex_display_scanner
    import display_pkg::*;
#(
    parameter int N_DIGITS  = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   blink_mask,
    input  logic                  alarm,
    input  logic                  lzb,
    input  logic                  enable,
    output logic [7:0]            seg,
    output logic [N_DIGITS-1:0]   an,
    output logic                  frame_done
);

    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int BLINK_W = $clog2(BLINK_DIV);
    localparam int IDX_W   = $clog2(N_DIGITS);

    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(N_DIGITS - 1);

    logic [SCAN_W-1:0]            scan_cnt_q;
    logic [BLINK_W-1:0]           blink_cnt_q;
    logic [IDX_W-1:0]             digit_idx_q;
    logic                         blink_phase_q;
    logic [N_DIGITS-1:0][3:0]     value_q;
    logic [N_DIGITS-1:0]          dp_q;
    logic [N_DIGITS-1:0]          blink_q;
    logic [7:0]                   seg_q;
    logic [N_DIGITS-1:0]          an_q;
    logic                         frame_done_q;

    logic                         slot_end;
    logic [3:0]                   cur_nib;
    logic [6:0]                   cur_glyph;
    logic [N_DIGITS:0]            upper_zero;
    logic                         blank;
    logic [7:0]                   seg_d;
    logic [N_DIGITS-1:0]          an_d;

    assign slot_end = (scan_cnt_q == SCAN_LAST);
    assign cur_nib  = value_q[digit_idx_q];

    // upper_zero[i] is set when nibbles i..N_DIGITS-1 are all zero.
    assign upper_zero[N_DIGITS] = 1'b1;
    for (genvar i = 0; i < N_DIGITS; i++) begin : g_lzb
        assign upper_zero[i] = upper_zero[i+1] & (value_q[i] == 4'h0);
    end

    hex_seg_decode u_decode (
        .nibble_i (cur_nib),
        .glyph_o  (cur_glyph)
    );

    always_comb begin
        blank = (scan_cnt_q == '0)
              | ~enable
              | (blink_q[digit_idx_q] & blink_phase_q)
              | (lzb & (digit_idx_q != '0) & upper_zero[digit_idx_q]);
        seg_d = SEG_BLANK;
        an_d  = '1;
        if (!blank) begin
            seg_d[SEG_G:SEG_A] = cur_glyph;
            seg_d[SEG_DP]      = ~(dp_q[digit_idx_q] | alarm);
            an_d[digit_idx_q]  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt_q    <= '0;
            digit_idx_q   <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            value_q       <= '0;
            dp_q          <= '0;
            blink_q       <= '0;
            seg_q         <= SEG_BLANK;
            an_q          <= '1;
            frame_done_q  <= 1'b0;
        end else begin
            if (load) begin
                value_q <= value;
                dp_q    <= dp_in;
                blink_q <= blink_mask;
            end

            if (slot_end) begin
                scan_cnt_q  <= '0;
                digit_idx_q <= (digit_idx_q == IDX_LAST) ? '0 : digit_idx_q + 1'b1;
            end else begin
                scan_cnt_q  <= scan_cnt_q + 1'b1;
            end
            frame_done_q <= slot_end & (digit_idx_q == IDX_LAST);

            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_q   <= '0;
                blink_phase_q <= ~blink_phase_q;
            end else begin
                blink_cnt_q   <= blink_cnt_q + 1'b1;
            end

            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule
